// File: rtl/vga_sprite_layer.sv
// Multi-sprite overlay for the VGA pixel path: N_SPR monochrome ROM sprites,
// frame-committed positions, 3-cycle pixel pipeline and per-frame collision flag.
module vga_sprite_layer #(
    parameter int unsigned        N_SPR   = 2,
    parameter int unsigned        COORD_W = 10,
    parameter int unsigned        SPR_W   = 10,
    parameter int unsigned        SPR_H   = 128,
    parameter int unsigned        ROW_AW  = 7,
    parameter logic [3*N_SPR-1:0] SPR_RGB = 6'b111_111,
    parameter logic [2:0]         BG_RGB  = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_pulse,
    input  logic                      pxl_en,
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic                      pos_we,
    input  logic [2:0]                pos_sel,
    input  logic [COORD_W-1:0]        pos_x,
    input  logic [COORD_W-1:0]        pos_y,
    output logic [N_SPR*ROW_AW-1:0]   rom_addr,
    input  logic [N_SPR*SPR_W-1:0]    rom_data,
    output logic                      r,
    output logic                      g,
    output logic                      b,
    output logic                      collision
);
    localparam int unsigned CMP_W = COORD_W + 1;
    localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;

    logic [N_SPR-1:0][COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [N_SPR-1:0][COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [N_SPR-1:0][ROW_AW-1:0]  rom_addr_q, rom_addr_d;
    logic [N_SPR-1:0][COL_W-1:0]   col1_q, col1_d, col2_q, col2_d;
    logic [N_SPR-1:0]              hit1_q, hit1_d, hit2_q, hit2_d;
    logic                          en1_q, en1_d, en2_q, en2_d;
    logic [2:0]                    rgb_q, rgb_d;
    logic                          sticky_q, sticky_d, coll_q, coll_d;

    logic [N_SPR-1:0][SPR_W-1:0]   word_c;
    logic [N_SPR-1:0]              opaque_c;
    logic                          multi_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            act_x_q    <= '0;
            act_y_q    <= '0;
            rom_addr_q <= '0;
            col1_q     <= '0;
            col2_q     <= '0;
            hit1_q     <= '0;
            hit2_q     <= '0;
            en1_q      <= 1'b0;
            en2_q      <= 1'b0;
            rgb_q      <= 3'b000;
            sticky_q   <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            rom_addr_q <= rom_addr_d;
            col1_q     <= col1_d;
            col2_q     <= col2_d;
            hit1_q     <= hit1_d;
            hit2_q     <= hit2_d;
            en1_q      <= en1_d;
            en2_q      <= en2_d;
            rgb_q      <= rgb_d;
            sticky_q   <= sticky_d;
            coll_q     <= coll_d;
        end
    end

    // Pending writes; commit uses the old pending value so a coincident write waits a frame.
    always_comb begin
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        for (int i = 0; i < int'(N_SPR); i++) begin
            if (pos_we && (pos_sel == 3'(i))) begin
                pend_x_d[i] = pos_x;
                pend_y_d[i] = pos_y;
            end
        end
        if (frame_pulse) begin
            act_x_d = pend_x_q;
            act_y_d = pend_y_q;
        end
    end

    // S1 hit test in COORD_W+1 bits so right/bottom edges clip instead of wrapping; S2 delay.
    always_comb begin
        rom_addr_d = rom_addr_q;
        hit1_d     = '0;
        col1_d     = '0;
        for (int i = 0; i < int'(N_SPR); i++) begin
            hit1_d[i] = pxl_en
                && ({1'b0, x} >= {1'b0, act_x_q[i]})
                && ({1'b0, x} <  ({1'b0, act_x_q[i]} + CMP_W'(SPR_W)))
                && ({1'b0, y} >= {1'b0, act_y_q[i]})
                && ({1'b0, y} <  ({1'b0, act_y_q[i]} + CMP_W'(SPR_H)));
            col1_d[i] = COL_W'(x - act_x_q[i]);
            if (hit1_d[i]) begin
                rom_addr_d[i] = ROW_AW'(y - act_y_q[i]);
            end
        end
        en1_d  = pxl_en;
        hit2_d = hit1_q;
        col2_d = col1_q;
        en2_d  = en1_q;
    end

    // S3: opacity, lowest-index priority, collision accumulation.
    always_comb begin
        word_c   = '0;
        opaque_c = '0;
        for (int i = 0; i < int'(N_SPR); i++) begin
            word_c[i]   = rom_data[i*SPR_W +: SPR_W] << col2_q[i];
            opaque_c[i] = en2_q && hit2_q[i] && word_c[i][SPR_W-1];
        end
        multi_c = (opaque_c & (opaque_c - N_SPR'(1))) != '0;

        rgb_d = en2_q ? BG_RGB : 3'b000;
        for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
            if (opaque_c[i]) begin
                rgb_d = SPR_RGB[3*i +: 3];
            end
        end

        sticky_d = sticky_q | multi_c;
        coll_d   = coll_q;
        if (frame_pulse) begin
            coll_d   = sticky_q | multi_c;
            sticky_d = 1'b0;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign r         = rgb_q[2];
    assign g         = rgb_q[1];
    assign b         = rgb_q[0];
    assign collision = coll_q;

endmodule
